// File: rtl/alarm_sequencer.sv
// Alarm ring sequencer: turns RTC alarm matches and stop/snooze pulses into a beep
// cadence on alarma_on, with ring timeout, bounded snoozes and a sticky missed flag.
module alarm_sequencer #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned BEEP_ON      = 2,
  parameter int unsigned BEEP_OFF     = 1,
  parameter int unsigned RING_MAX     = 60,
  parameter int unsigned SNOOZE_TICKS = 300,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alarm_en,
  input  logic                            alarm_match,
  input  logic                            stop_btn,
  input  logic                            snooze_btn,
  output logic                            alarma_on,
  output logic                            alarm_active,
  output logic                            snoozing,
  output logic                            alarm_missed,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_left
);

  localparam int unsigned BeepMaxA = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int unsigned BeepMax  = (BeepMaxA > SNOOZE_TICKS) ? BeepMaxA : SNOOZE_TICKS;
  localparam int unsigned PresW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BeepW    = (BeepMax > 1) ? $clog2(BeepMax) : 1;
  localparam int unsigned RingW    = (RING_MAX > 1) ? $clog2(RING_MAX) : 1;
  localparam int unsigned SnzW     = $clog2(MAX_SNOOZE + 1);

  typedef enum logic [1:0] {StIdle, StRingOn, StRingOff, StSnooze} state_e;

  state_e            state_q, state_d;
  logic [PresW-1:0]  presc_q, presc_d;
  logic [BeepW-1:0]  beep_cnt_q, beep_cnt_d;
  logic [RingW-1:0]  ring_cnt_q, ring_cnt_d;
  logic [SnzW-1:0]   snooze_left_q, snooze_left_d;
  logic              missed_q, missed_d;
  logic              alarma_on_q, alarm_active_q, snoozing_q;

  logic tick;
  logic ringing;
  logic transition;

  assign tick    = (state_q != StIdle) && (presc_q == PresW'(TICK_DIV - 1));
  assign ringing = (state_q == StRingOn) || (state_q == StRingOff);

  // Next-state decode, branches in strict priority order.
  always_comb begin
    state_d       = state_q;
    missed_d      = missed_q;
    snooze_left_d = snooze_left_q;
    if (!alarm_en || stop_btn) begin
      state_d = StIdle;
      if (stop_btn) missed_d = 1'b0;
    end else if (ringing && snooze_btn && (snooze_left_q != '0)) begin
      state_d       = StSnooze;
      snooze_left_d = snooze_left_q - SnzW'(1);
    end else if (ringing && tick && (ring_cnt_q == RingW'(RING_MAX - 1))) begin
      state_d  = StIdle;
      missed_d = 1'b1;
    end else if (tick) begin
      case (state_q)
        StRingOn:  if (beep_cnt_q == BeepW'(BEEP_ON - 1))      state_d = StRingOff;
        StRingOff: if (beep_cnt_q == BeepW'(BEEP_OFF - 1))     state_d = StRingOn;
        StSnooze:  if (beep_cnt_q == BeepW'(SNOOZE_TICKS - 1)) state_d = StRingOn;
        default:   state_d = state_q;
      endcase
    end else if ((state_q == StIdle) && alarm_match) begin
      state_d = StRingOn;
    end
    // Keeps the snooze budget full for as long as the sequencer sits idle.
    if (state_d == StIdle) snooze_left_d = SnzW'(MAX_SNOOZE);
  end

  assign transition = (state_d != state_q);

  // Prescaler and tick counters; every state change restarts dwell timing.
  always_comb begin
    presc_d    = presc_q + PresW'(1);
    beep_cnt_d = beep_cnt_q;
    ring_cnt_d = ring_cnt_q;
    if ((state_d == StIdle) || transition || tick) presc_d = '0;

    if (transition)  beep_cnt_d = '0;
    else if (tick)   beep_cnt_d = beep_cnt_q + BeepW'(1);

    if ((state_d == StIdle) ||
        ((state_d == StRingOn) && ((state_q == StIdle) || (state_q == StSnooze)))) begin
      ring_cnt_d = '0;
    end else if (tick && ringing && (state_d != StSnooze)) begin
      ring_cnt_d = ring_cnt_q + RingW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      beep_cnt_q     <= '0;
      ring_cnt_q     <= '0;
      snooze_left_q  <= SnzW'(MAX_SNOOZE);
      missed_q       <= 1'b0;
      alarma_on_q    <= 1'b0;
      alarm_active_q <= 1'b0;
      snoozing_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      beep_cnt_q     <= beep_cnt_d;
      ring_cnt_q     <= ring_cnt_d;
      snooze_left_q  <= snooze_left_d;
      missed_q       <= missed_d;
      alarma_on_q    <= (state_d == StRingOn);
      alarm_active_q <= (state_d != StIdle);
      snoozing_q     <= (state_d == StSnooze);
    end
  end

  assign alarma_on    = alarma_on_q;
  assign alarm_active = alarm_active_q;
  assign snoozing     = snoozing_q;
  assign alarm_missed = missed_q;
  assign snooze_left  = snooze_left_q;

endmodule
